// File: rtl/param_updown_cntr.sv
// Parametrised up/down counter with load, programmable terminal value,
// wrap-or-saturate limit handling, one-cycle terminal-count pulse and sticky overflow.
module param_updown_cntr #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned STEP     = 1,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned RST_VAL  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] RST_W    = WIDTH'(RST_VAL);
    localparam bit               SAT      = (SATURATE != 0);

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             ovf_nxt;
    logic             limit_hit;

    // Next-state: load beats enable; the up compare runs one bit wider so count+STEP never truncates.
    always_comb begin
        sum_ext   = {1'b0, count} + STEP_EXT;
        count_nxt = count;
        tc_nxt    = 1'b0;
        limit_hit = 1'b0;
        if (load) begin
            count_nxt = load_val;
        end else if (en) begin
            if (up) begin
                if (sum_ext > {1'b0, term_val}) begin
                    limit_hit = 1'b1;
                    count_nxt = SAT ? term_val : '0;
                end else begin
                    count_nxt = sum_ext[WIDTH-1:0];
                    tc_nxt    = SAT && (sum_ext[WIDTH-1:0] == term_val);
                end
            end else begin
                if (count < STEP_W) begin
                    limit_hit = 1'b1;
                    count_nxt = SAT ? '0 : term_val;
                end else begin
                    count_nxt = count - STEP_W;
                end
            end
        end
        tc_nxt  = tc_nxt | limit_hit;
        // A new limit event outranks a simultaneous clear.
        ovf_nxt = limit_hit | (ovf & ~clr_ovf);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= RST_W;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt;
            tc    <= tc_nxt;
            ovf   <= ovf_nxt;
        end
    end

endmodule
